memwb_skid_stage: RTL and testbench

- Parametrised successor to the fixed MEM/WB pipeline register.
- Carries control bits, memory read data, ALU result, R15 value and destination register index from MEM to WB.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so WB back-pressure does not lose an in-flight instruction.
- Adds synchronous flush and invalid-slot control gating.
- Sits between the data-memory stage and the register-file write port.

---
 rtl/memwb_skid_stage.sv | 159 +++++++++++++++
 tb/tb_memwb_skid_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_skid_stage.sv
// memwb_skid_stage
//
// MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid
// buffer. The head register M drives the WB-side outputs. The skid register S
// catches the one instruction that can arrive while WB is stalling.
//
//   state | meaning
//   EMPTY | M and S both invalid
//   ONE   | M valid, S invalid
//   FULL  | M and S both valid (in_ready low)
//
// Ports:
//   clk, rst (async, active-low)  clock and reset
//   flush                         synchronous kill of both held entries
//   in_valid / in_ready           MEM-side handshake
//   in_ctrl/rdata/res/r15/dest    incoming fields
//   out_valid / out_ready         WB-side handshake
//   out_ctrl/rdata/res/r15/dest   head-entry fields; out_ctrl is zero when invalid
//
// Optional feature (macro MEMWB_STATS_EN):
//   stats_clr, stall_cnt[15:0], bubble_cnt[15:0] are saturating
//   performance counters. flush does not clear them.
module memwb_skid_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEMWB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt,
`endif
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [DATA_W-1:0] in_res,
    input  logic [DATA_W-1:0] in_r15,
    input  logic [REG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] out_res,
    output logic [DATA_W-1:0] out_r15,
    output logic [REG_W-1:0]  out_dest
);

    localparam int PW = CTRL_W + 3 * DATA_W + REG_W;

    logic          m_valid_q, m_valid_d;
    logic          s_valid_q, s_valid_d;
    logic [PW-1:0] m_data_q,  m_data_d;
    logic [PW-1:0] s_data_q,  s_data_d;
    logic          m_en, s_en;
    logic          in_fire, out_fire;
    logic [PW-1:0] in_data;
    logic [CTRL_W-1:0] m_ctrl;

    assign in_data  = {in_ctrl, in_rdata, in_res, in_r15, in_dest};
    assign in_ready = ~s_valid_q;
    assign out_valid = m_valid_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = in_data;
        s_data_d  = in_data;
        m_en      = 1'b0;
        s_en      = 1'b0;
        if (flush) begin
            // Flush beats every transfer; data registers keep stale contents.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q) begin
            if (in_fire) begin
                m_valid_d = 1'b1;
                m_en      = 1'b1;
            end
        end else if (!s_valid_q) begin
            if (in_fire && out_fire) begin
                m_en = 1'b1;
            end else if (in_fire) begin
                s_valid_d = 1'b1;
                s_en      = 1'b1;
            end else if (out_fire) begin
                m_valid_d = 1'b0;
            end
        end else if (out_fire) begin
            // FULL: in_ready is low, so only the skid-to-head move can happen.
            m_data_d  = s_data_q;
            m_en      = 1'b1;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    // Data registers only toggle on load to keep switching activity down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data_q <= '0;
            s_data_q <= '0;
        end else begin
            if (m_en) m_data_q <= m_data_d;
            if (s_en) s_data_q <= s_data_d;
        end
    end

    assign {m_ctrl, out_rdata, out_res, out_r15, out_dest} = m_data_q;
    // An invalid slot must never present regWrite or R15Write to WB.
    assign out_ctrl = m_valid_q ? m_ctrl : '0;

`ifdef MEMWB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stats_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (m_valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
                stall_cnt_d = stall_cnt_q + 16'd1;
            if (!m_valid_q && bubble_cnt_q != 16'hFFFF)
                bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Testbench for memwb_skid_stage: directed scenarios plus randomized traffic
// checked against a depth-2 FIFO reference model.
module tb_memwb_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [15:0] in_rdata, in_res, in_r15;
    logic [3:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ctrl;
    logic [15:0] out_rdata, out_res, out_r15;
    logic [3:0]  out_dest;
`ifdef MEMWB_STATS_EN
    logic        stats_clr;
    logic [15:0] stall_cnt, bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [15:0] rdata;
        logic [15:0] res;
        logic [15:0] r15;
        logic [3:0]  dest;
    } entry_t;

    entry_t model_q[$];
    int     exp_stall  = 0;
    int     exp_bubble = 0;
    logic   clr_in;

    memwb_skid_stage #(.DATA_W(16), .REG_W(4), .CTRL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MEMWB_STATS_EN
        .stats_clr (stats_clr),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rdata  (in_rdata),
        .in_res    (in_res),
        .in_r15    (in_r15),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_rdata (out_rdata),
        .out_res   (out_res),
        .out_r15   (out_r15),
        .out_dest  (out_dest)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and update the reference FIFO from the inputs
    // that were stable before the edge. Returns 1 time unit after the edge.
    task automatic cycle();
        bit     do_in, do_out;
        bit     stall_now, bubble_now;
        entry_t e;
`ifdef MEMWB_STATS_EN
        clr_in = stats_clr;
`else
        clr_in = 1'b0;
`endif
        do_in      = in_valid && (model_q.size() < 2);
        do_out     = (model_q.size() > 0) && out_ready;
        stall_now  = (model_q.size() > 0) && !out_ready;
        bubble_now = (model_q.size() == 0);
        e.ctrl = in_ctrl; e.rdata = in_rdata; e.res = in_res; e.r15 = in_r15; e.dest = in_dest;
        @(posedge clk);
        if (!rst) begin
            model_q.delete();
            exp_stall = 0;
            exp_bubble = 0;
        end else begin
            if (flush) begin
                model_q.delete();
            end else begin
                if (do_out) void'(model_q.pop_front());
                if (do_in) model_q.push_back(e);
            end
            if (clr_in) begin
                exp_stall = 0;
                exp_bubble = 0;
            end else begin
                if (stall_now && exp_stall < 65535) exp_stall++;
                if (bubble_now && exp_bubble < 65535) exp_bubble++;
            end
        end
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [3:0] c, input logic [15:0] r, input logic [3:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_res   = r;
        in_dest  = d;
        in_rdata = r ^ 16'h5A5A;
        in_r15   = r + 16'h0100;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_ctrl !== 4'b0000) begin errors++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_dest !== 4'h0 || out_res !== 16'h0) begin
            errors++; $display("FAIL reset_fields got dest=%h res=%h exp=0", out_dest, out_res);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        drive_in(1'b1, 4'b0001, 16'h1234, 4'h3);
        cycle();
        drive_in(1'b0, 4'b0000, 16'h0000, 4'h0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_res !== 16'h1234 || out_dest !== 4'h3 || out_ctrl !== 4'b0001) begin
            errors++;
            $display("FAIL stream_first got v=%b res=%h dest=%h ctrl=%b exp v=1 res=1234 dest=3 ctrl=0001",
                     out_valid, out_res, out_dest, out_ctrl);
        end
        cycle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_in(1'b1, 4'b0001, 16'h00A1, 4'h1);
        cycle();
        drive_in(1'b1, 4'b0101, 16'h00B2, 4'h2);
        cycle();
        drive_in(1'b0, 4'b0000, 16'h0000, 4'h0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_res !== 16'h00A1) begin
            errors++;
            $display("FAIL bp_full got rdy=%b v=%b res=%h exp rdy=0 v=1 res=00a1", in_ready, out_valid, out_res);
        end
        cycle();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_res !== 16'h00A1 || out_dest !== 4'h1) begin
            errors++; $display("FAIL bp_first got v=%b res=%h exp v=1 res=00a1", out_valid, out_res);
        end
        cycle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_res !== 16'h00B2 || out_ctrl !== 4'b0101 || out_dest !== 4'h2) begin
            errors++; $display("FAIL bp_second got v=%b res=%h ctrl=%b exp v=1 res=00b2 ctrl=0101", out_valid, out_res, out_ctrl);
        end
        cycle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_in(1'b1, 4'b1111, 16'h0C01, 4'h5);
        cycle();
        drive_in(1'b1, 4'b1111, 16'h0C02, 4'h6);
        cycle();
        drive_in(1'b1, 4'b1111, 16'h0C03, 4'h7);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive_in(1'b0, 4'b0000, 16'h0000, 4'h0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 4'b0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state got v=%b ctrl=%b rdy=%b exp v=0 ctrl=0000 rdy=1", out_valid, out_ctrl, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got v=%b res=%h exp v=0", out_valid, out_res); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_in(1'b1, 4'b0011, 16'h0D01, 4'h8);
        cycle();
        drive_in(1'b1, 4'b0011, 16'h0D02, 4'h9);
        cycle();
        drive_in(1'b0, 4'b0000, 16'h0000, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        exp_stall = 0;
        exp_bubble = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_res !== 16'h0000 || in_ready !== 1'b1 || out_ctrl !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got v=%b res=%h rdy=%b ctrl=%b exp v=0 res=0000 rdy=1 ctrl=0", out_valid, out_res, in_ready, out_ctrl);
        end
        cycle();
        rst = 1'b1;
        out_ready = 1'b1;
        drive_in(1'b1, 4'b0001, 16'h0E0E, 4'hE);
        cycle();
        drive_in(1'b0, 4'b0000, 16'h0000, 4'h0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_res !== 16'h0E0E) begin
            errors++; $display("FAIL post_reset got v=%b res=%h exp v=1 res=0e0e", out_valid, out_res);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        int seen;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive_in(1'b1, 4'b0001, 16'h0100 + 16'(i), 4'(i));
            else       drive_in(1'b0, 4'b0000, 16'h0000, 4'h0);
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_res !== 16'h0100 + 16'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_out[%0d] got v=%b res=%h exp v=1 res=%h", i, out_valid, out_res, 16'h0100 + 16'(i - 1));
                end else seen++;
            end
            cycle();
        end
        checks++;
        if (seen != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", seen); end
    endtask

    task automatic test_random();
        entry_t h;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            in_ctrl   = 4'($urandom);
            in_rdata  = 16'($urandom);
            in_res    = 16'($urandom);
            in_r15    = 16'($urandom);
            in_dest   = 4'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_hs[%0d] got v=%b rdy=%b exp occupancy=%0d", i, out_valid, in_ready, model_q.size());
            end
            if (model_q.size() > 0) begin
                h = model_q[0];
                checks++;
                if (out_ctrl !== h.ctrl || out_rdata !== h.rdata || out_res !== h.res ||
                    out_r15 !== h.r15 || out_dest !== h.dest) begin
                    errors++;
                    $display("FAIL rnd_data[%0d] got %h/%h/%h/%h/%h exp %h/%h/%h/%h/%h", i,
                             out_ctrl, out_rdata, out_res, out_r15, out_dest, h.ctrl, h.rdata, h.res, h.r15, h.dest);
                end
            end else begin
                checks++;
                if (out_ctrl !== 4'b0000) begin errors++; $display("FAIL rnd_gate[%0d] got ctrl=%b exp 0000", i, out_ctrl); end
            end
            cycle();
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

`ifdef MEMWB_STATS_EN
    task automatic test_stats();
        out_ready = 1'b0;
        drive_in(1'b0, 4'b0000, 16'h0000, 4'h0);
        flush = 1'b1;
        stats_clr = 1'b1;
        cycle();
        flush = 1'b0;
        stats_clr = 1'b0;
        drive_in(1'b1, 4'b0001, 16'h0F0F, 4'h1);
        cycle();
        drive_in(1'b0, 4'b0000, 16'h0000, 4'h0);
        for (int i = 0; i < 5; i++) cycle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_5 got=%0d exp=5", stall_cnt); end
        checks++;
        if (bubble_cnt !== 16'(exp_bubble)) begin errors++; $display("FAIL bubble_cnt got=%0d exp=%0d", bubble_cnt, exp_bubble); end
        stats_clr = 1'b1;
        cycle();
        stats_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            errors++; $display("FAIL stats_clr got stall=%0d bubble=%0d exp 0/0", stall_cnt, bubble_cnt);
        end
        for (int i = 0; i < 70000; i++) cycle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'hFFFF || 16'(exp_stall) !== 16'hFFFF) begin
            errors++; $display("FAIL stall_sat got=%h exp=ffff", stall_cnt);
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'(exp_stall) || bubble_cnt !== 16'(exp_bubble)) begin
            errors++;
            $display("FAIL stats_flush got stall=%h bubble=%h exp stall=%h bubble=%h", stall_cnt, bubble_cnt, 16'(exp_stall), 16'(exp_bubble));
        end
        cycle();
    endtask
`endif

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
`ifdef MEMWB_STATS_EN
        stats_clr = 1'b0;
`endif
        drive_in(1'b0, 4'b0000, 16'h0000, 4'h0);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
`ifdef MEMWB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
